// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the memory port.
// The master modport is the arbiter's view; slave is the CPU and memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch side
    logic          IF_Req;
    logic [AW-1:0] IF_Addr;
    logic          IF_Ack;
    logic [DW-1:0] IF_RData;
    // Load/store side
    logic          MEM_Rd;
    logic          MEM_Wr;
    logic [AW-1:0] MEM_Addr;
    logic [DW-1:0] MEM_WData;
    logic [3:0]    MEM_BE;
    logic          MEM_Ack;
    logic [DW-1:0] MEM_RData;
    // Memory port: M_Valid/M_Ready handshake. A transfer completes on a rising edge
    // where both are 1; request fields stay stable while M_Valid=1; M_Ready is
    // ignored while M_Valid=0; M_RData is only meaningful while M_Ready=1.
    logic          M_Valid;
    logic          M_Wr;
    logic [AW-1:0] M_Addr;
    logic [DW-1:0] M_WData;
    logic [3:0]    M_BE;
    logic          M_Ready;
    logic [DW-1:0] M_RData;
    // Status and pipeline control
    logic          Bus_Err;
    logic          PCWre;
    logic          IFID_Stall;
    logic          Pipe_Stall;

    modport master (
        input  IF_Req, IF_Addr, MEM_Rd, MEM_Wr, MEM_Addr, MEM_WData, MEM_BE,
        input  M_Ready, M_RData,
        output IF_Ack, IF_RData, MEM_Ack, MEM_RData,
        output M_Valid, M_Wr, M_Addr, M_WData, M_BE,
        output Bus_Err, PCWre, IFID_Stall, Pipe_Stall
    );

    modport slave (
        output IF_Req, IF_Addr, MEM_Rd, MEM_Wr, MEM_Addr, MEM_WData, MEM_BE,
        output M_Ready, M_RData,
        input  IF_Ack, IF_RData, MEM_Ack, MEM_RData,
        input  M_Valid, M_Wr, M_Addr, M_WData, M_BE,
        input  Bus_Err, PCWre, IFID_Stall, Pipe_Stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported unified memory between IF fetch and MEM load/store,
// with MEM priority, completion masking, a hang watchdog and pipeline freeze outputs.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    mem_port_arbiter_if.master bus,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_MEM = 2'd1,
        GNT_IF  = 2'd2
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t        state, state_next;
    logic          grant_mem, grant_if;
    logic          mem_req, done, abort, end_txn;
    logic          m_valid, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_be;
    logic          if_ack, mem_ack, bus_err;
    logic [DW-1:0] if_rdata, mem_rdata;
    logic [7:0]    wdog;
    logic          mem_wait, if_wait;

    assign mem_req = bus.MEM_Rd | bus.MEM_Wr;
    assign done    = m_valid & bus.M_Ready;
    assign abort   = m_valid & ~bus.M_Ready & (wdog == WD_LAST);
    assign end_txn = done | abort;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // The requester that just finished is not eligible at its own end edge,
    // so a continuously held request cannot be granted twice in a row.
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req)         grant_mem = 1'b1;
                else if (bus.IF_Req) grant_if  = 1'b1;
            end
            GNT_MEM: begin
                if (end_txn) begin
                    if (bus.IF_Req) grant_if   = 1'b1;
                    else            state_next = IDLE;
                end
            end
            GNT_IF: begin
                if (end_txn) begin
                    if (mem_req) grant_mem  = 1'b1;
                    else         state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (grant_mem) state_next = GNT_MEM;
        if (grant_if)  state_next = GNT_IF;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            m_valid   <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_be      <= 4'hF;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            bus_err   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            wdog      <= '0;
        end else begin
            m_valid <= grant_mem | grant_if | (m_valid & ~end_txn);
            if_ack  <= end_txn & (state == GNT_IF);
            mem_ack <= end_txn & (state == GNT_MEM);
            bus_err <= abort;
            if (grant_mem) begin
                m_addr  <= bus.MEM_Addr;
                m_wr    <= bus.MEM_Wr;
                m_wdata <= bus.MEM_WData;
                m_be    <= bus.MEM_Wr ? bus.MEM_BE : 4'hF;
            end else if (grant_if) begin
                m_addr <= bus.IF_Addr;
                m_wr   <= 1'b0;
                m_be   <= 4'hF;
            end
            if (done && state == GNT_IF)
                if_rdata <= bus.M_RData;
            if (done && state == GNT_MEM && !m_wr)
                mem_rdata <= bus.M_RData;
            if (grant_mem || grant_if || end_txn)
                wdog <= '0;
            else if (m_valid && !bus.M_Ready)
                wdog <= wdog + 8'd1;
        end
    end

    // Freeze the pipeline while a requester is still waiting for its Ack.
    assign mem_wait = mem_req & ~mem_ack;
    assign if_wait  = bus.IF_Req & ~if_ack;

    assign bus.Pipe_Stall = mem_wait;
    assign bus.PCWre      = ~(mem_wait | if_wait);
    assign bus.IFID_Stall = mem_wait | if_wait;

    assign bus.M_Valid   = m_valid;
    assign bus.M_Wr      = m_wr;
    assign bus.M_Addr    = m_addr;
    assign bus.M_WData   = m_wdata;
    assign bus.M_BE      = m_be;
    assign bus.IF_Ack    = if_ack;
    assign bus.IF_RData  = if_rdata;
    assign bus.MEM_Ack   = mem_ack;
    assign bus.MEM_RData = mem_rdata;
    assign bus.Bus_Err   = bus_err;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, store stability,
// masking, watchdog abort and asynchronous reset, checked with immediate assertions.
module tb_mem_port_arbiter;
    localparam logic [1:0] S_IDLE = 2'd0, S_MEM = 2'd1, S_IF = 2'd2;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [1:0] state_dbg;
    int         tests = 0;
    int         fails = 0;
    int         ack_cnt;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.IF_Req    = 1'b0;
        bus.IF_Addr   = '0;
        bus.MEM_Rd    = 1'b0;
        bus.MEM_Wr    = 1'b0;
        bus.MEM_Addr  = '0;
        bus.MEM_WData = '0;
        bus.MEM_BE    = 4'h0;
        bus.M_Ready   = 1'b0;
        bus.M_RData   = '0;
    endtask

    initial begin
        Reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_valid", bus.M_Valid, 0);
        chk("rst_be", bus.M_BE, 4'hF);
        chk("rst_addr", bus.M_Addr, 0);
        chk("rst_ifrdata", bus.IF_RData, 0);
        chk("rst_memrdata", bus.MEM_RData, 0);
        chk("rst_acks", {bus.IF_Ack, bus.MEM_Ack, bus.Bus_Err}, 0);
        chk("rst_state", state_dbg, S_IDLE);
        chk("rst_pcwre", bus.PCWre, 1);
        Reset = 1'b1;
        tick();

        // Single fetch with zero-wait memory
        bus.IF_Req = 1'b1; bus.IF_Addr = 32'h100;
        bus.M_Ready = 1'b1; bus.M_RData = 32'h2402000A;
        #1;
        chk("f_c0_pcwre", bus.PCWre, 0);
        chk("f_c0_ifid", bus.IFID_Stall, 1);
        chk("f_c0_valid", bus.M_Valid, 0);
        tick();
        chk("f_c1_valid", bus.M_Valid, 1);
        chk("f_c1_state", state_dbg, S_IF);
        chk("f_c1_addr", bus.M_Addr, 32'h100);
        chk("f_c1_wr_be", {bus.M_Wr, bus.M_BE}, 5'h0F);
        chk("f_c1_pcwre", bus.PCWre, 0);
        tick();
        chk("f_c2_ack", bus.IF_Ack, 1);
        chk("f_c2_rdata", bus.IF_RData, 32'h2402000A);
        chk("f_c2_pcwre", bus.PCWre, 1);
        chk("f_c2_valid", bus.M_Valid, 0);
        bus.IF_Req = 1'b0; bus.M_Ready = 1'b0;
        tick();
        chk("f_c3_ack", bus.IF_Ack, 0);
        chk("f_c3_state", state_dbg, S_IDLE);

        // Simultaneous IF and MEM requests, memory answers after 2 cycles
        bus.IF_Req = 1'b1; bus.IF_Addr = 32'h104;
        bus.MEM_Rd = 1'b1; bus.MEM_Addr = 32'h200;
        #1;
        chk("s_c0_pstall", bus.Pipe_Stall, 1);
        tick();
        chk("s_c1_state", state_dbg, S_MEM);
        chk("s_c1_addr", bus.M_Addr, 32'h200);
        tick();
        bus.M_Ready = 1'b1; bus.M_RData = 32'h11112222;
        #1;
        chk("s_c2_pstall", bus.Pipe_Stall, 1);
        tick();
        chk("s_c3_memack", bus.MEM_Ack, 1);
        chk("s_c3_memrdata", bus.MEM_RData, 32'h11112222);
        chk("s_c3_state", state_dbg, S_IF);
        chk("s_c3_valid", bus.M_Valid, 1);
        chk("s_c3_addr", bus.M_Addr, 32'h104);
        chk("s_c3_pstall", bus.Pipe_Stall, 0);
        chk("s_c3_pcwre", bus.PCWre, 0);
        bus.MEM_Rd = 1'b0; bus.M_Ready = 1'b0;
        tick();
        chk("s_c4_memack", bus.MEM_Ack, 0);
        bus.M_Ready = 1'b1; bus.M_RData = 32'h33334444;
        tick();
        chk("s_c5_ifack", bus.IF_Ack, 1);
        chk("s_c5_ifrdata", bus.IF_RData, 32'h33334444);
        chk("s_c5_state", state_dbg, S_IDLE);
        bus.IF_Req = 1'b0; bus.M_Ready = 1'b0;
        tick();

        // Store with 3 wait cycles; requester changes its inputs mid-transfer
        bus.MEM_Wr = 1'b1; bus.MEM_Addr = 32'h300;
        bus.MEM_WData = 32'hCAFEBABE; bus.MEM_BE = 4'b0011;
        tick();
        chk("w_c1_wr", bus.M_Wr, 1);
        chk("w_c1_be", bus.M_BE, 4'b0011);
        chk("w_c1_wdata", bus.M_WData, 32'hCAFEBABE);
        tick();
        bus.MEM_WData = 32'hDEADBEEF; bus.MEM_Addr = 32'h3FC; bus.MEM_BE = 4'hC;
        tick();
        chk("w_c3_wdata", bus.M_WData, 32'hCAFEBABE);
        chk("w_c3_addr", bus.M_Addr, 32'h300);
        chk("w_c3_be", bus.M_BE, 4'b0011);
        chk("w_c3_valid", bus.M_Valid, 1);
        tick();
        chk("w_c4_wdata", bus.M_WData, 32'hCAFEBABE);
        chk("w_c4_ack", bus.MEM_Ack, 0);
        bus.M_Ready = 1'b1; bus.M_RData = 32'h55555555;
        tick();
        chk("w_c5_ack", bus.MEM_Ack, 1);
        chk("w_c5_err", bus.Bus_Err, 0);
        chk("w_c5_memrdata", bus.MEM_RData, 32'h11112222);
        chk("w_c5_state", state_dbg, S_IDLE);
        bus.MEM_Wr = 1'b0; bus.M_Ready = 1'b0;
        tick();

        // IF_Req held high across completions: grants alternate with idle cycles
        bus.IF_Req = 1'b1; bus.IF_Addr = 32'h400;
        bus.M_Ready = 1'b1; bus.M_RData = 32'h0BADF00D;
        ack_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("m_state_%0d", i), state_dbg, (i % 2 == 1) ? S_IF : S_IDLE);
            chk($sformatf("m_ack_%0d", i), bus.IF_Ack, (i % 2 == 0) ? 1 : 0);
            if (bus.IF_Ack) ack_cnt++;
        end
        bus.IF_Req = 1'b0; bus.M_Ready = 1'b0;
        tick();
        chk("m_ack_cnt", ack_cnt, 3);
        chk("m_end_state", state_dbg, S_IDLE);

        // Watchdog abort of a hung load with a fetch pending
        bus.MEM_Rd = 1'b1; bus.MEM_Addr = 32'h500;
        bus.IF_Req = 1'b1; bus.IF_Addr = 32'h600;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t_valid_%0d", i), {bus.M_Valid, state_dbg}, {1'b1, S_MEM});
            chk($sformatf("t_addr_%0d", i), bus.M_Addr, 32'h500);
            chk($sformatf("t_noack_%0d", i), {bus.MEM_Ack, bus.Bus_Err}, 0);
        end
        tick();
        chk("t_memack", bus.MEM_Ack, 1);
        chk("t_buserr", bus.Bus_Err, 1);
        chk("t_memrdata", bus.MEM_RData, 32'h11112222);
        chk("t_next_state", state_dbg, S_IF);
        chk("t_next_addr", bus.M_Addr, 32'h600);
        chk("t_ifack", bus.IF_Ack, 0);
        bus.MEM_Rd = 1'b0;
        bus.M_Ready = 1'b1; bus.M_RData = 32'h77778888;
        tick();
        chk("t_if_ack", bus.IF_Ack, 1);
        chk("t_if_rdata", bus.IF_RData, 32'h77778888);
        chk("t_err_clear", {bus.Bus_Err, bus.MEM_Ack}, 0);
        bus.IF_Req = 1'b0; bus.M_Ready = 1'b0;
        tick();

        // Watchdog abort of a lone fetch: M_Valid drops after 4 cycles high
        bus.IF_Req = 1'b1; bus.IF_Addr = 32'h800;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("tf_valid_%0d", i), bus.M_Valid, 1);
        end
        tick();
        chk("tf_valid_drop", bus.M_Valid, 0);
        chk("tf_ack_err", {bus.IF_Ack, bus.Bus_Err}, 2'b11);
        chk("tf_ifrdata", bus.IF_RData, 32'h77778888);
        bus.IF_Req = 1'b0;
        tick();
        chk("tf_err_pulse", bus.Bus_Err, 0);

        // Asynchronous reset while a load waits
        bus.MEM_Rd = 1'b1; bus.MEM_Addr = 32'h700;
        tick();
        tick();
        chk("r_pre_state", state_dbg, S_MEM);
        #1 Reset = 1'b0;
        #1;
        chk("r_valid", bus.M_Valid, 0);
        chk("r_state", state_dbg, S_IDLE);
        chk("r_addr", bus.M_Addr, 0);
        chk("r_memrdata", bus.MEM_RData, 0);
        bus.MEM_Rd = 1'b0;
        tick();
        chk("r_noack", {bus.MEM_Ack, bus.IF_Ack, bus.Bus_Err}, 0);
        Reset = 1'b1;
        tick();
        chk("r_post_state", state_dbg, S_IDLE);
        chk("r_post_pcwre", bus.PCWre, 1);
        chk("r_post_valid", bus.M_Valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF-stage fetch and the MEM-stage load/store of the pipelined CPU.
- Sequences each memory transaction with a valid/ready handshake.
- Generates the pipeline freeze controls (PCWre, IFID_Stall, Pipe_Stall) for as long as a requester is waiting on the port.
- Aborts hung transactions with a watchdog.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum cycles M_Valid may stay high without M_Ready before the transaction is aborted (2..255).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IF_Req  in  1  fetch request; held until IF_Ack.
- IF_Addr  in  AW  fetch address.
- IF_Ack  out  1  one-cycle pulse: fetch done.
- IF_RData  out  DW  fetched word, registered.
- MEM_Rd  in  1  load request; held until MEM_Ack.
- MEM_Wr  in  1  store request; held until MEM_Ack.
- MEM_Addr  in  AW  load/store address.
- MEM_WData  in  DW  store data.
- MEM_BE  in  4  store byte enables.
- MEM_Ack  out  1  one-cycle pulse: load/store done.
- MEM_RData  out  DW  load data, registered.
- M_Valid  out  1  memory request valid.
- M_Wr  out  1  1 = write.
- M_Addr  out  AW  memory address.
- M_WData  out  DW  memory write data.
- M_BE  out  4  memory byte enables; 4'hF on reads.
- M_Ready  in  1  memory completes the transaction this cycle.
- M_RData  in  DW  read data, valid while M_Ready=1.
- Bus_Err  out  1  one-cycle pulse on watchdog abort.
- PCWre  out  1  PC write enable.
- IFID_Stall  out  1  hold the IF/ID register.
- Pipe_Stall  out  1  freeze ID/EX, EX/MEM and MEM/WB.

Behaviour:
- Reset (Reset=0, asynchronous, effective immediately even mid-transaction):
  - State goes to IDLE.
  - M_Valid, M_Wr, IF_Ack, MEM_Ack and Bus_Err go to 0.
  - M_Addr, M_WData, IF_RData, MEM_RData and the watchdog counter go to 0.
  - M_BE goes to 4'hF.
- States:
  - IDLE: no transaction; M_Valid=0.
  - GNT_MEM: serving a load/store.
  - GNT_IF: serving a fetch.
- Grant decision:
  - Priority: MEM over IF, because the older instruction must drain.
  - From IDLE: if MEM_Rd|MEM_Wr, go to GNT_MEM. Else if IF_Req, go to GNT_IF.
  - On grant, M_Addr, M_Wr, M_WData and M_BE are registered from the winner's inputs.
  - M_Valid=1 from the cycle after the grant decision.
  - M_Wr=MEM_Wr. If MEM_Rd and MEM_Wr are both 1, the write wins and the read is ignored.
  - Request fields stay stable while M_Valid=1, whatever the requester inputs do.
- Completion (rising edge with M_Valid=1 and M_Ready=1):
  - For a fetch, IF_RData<=M_RData.
  - For a load, MEM_RData<=M_RData.
  - For a store, MEM_RData is unchanged.
  - The matching Ack pulses high for exactly the following cycle.
  - The next grant is chosen in the same edge, but only from the other requester; the completing requester is masked for one cycle. No idle bubble when the other requester is pending; otherwise go to IDLE.
- Minimum latency: request seen in IDLE at cycle 0, M_Valid in cycle 1, M_Ready=1 in cycle 1, Ack in cycle 2.
- IF_RData and MEM_RData hold their values until the next corresponding completion.
- Watchdog:
  - The counter increments each cycle M_Valid=1 and M_Ready=0.
  - It clears on completion or grant.
  - When the counter reaches TIMEOUT-1 with M_Ready still 0: drop M_Valid at that edge, pulse the granted requester's Ack and Bus_Err together next cycle, leave the RData register unchanged, and re-arbitrate using the completion masking rule.
- Stall outputs (combinational from inputs and registered Acks):
  - mem_wait = (MEM_Rd|MEM_Wr) & ~MEM_Ack
  - if_wait = IF_Req & ~IF_Ack
  - Pipe_Stall = mem_wait
  - PCWre = ~(mem_wait | if_wait)
  - IFID_Stall = ~PCWre
- M_Ready while M_Valid=0 is ignored.
- A request dropped before its Ack is a protocol violation. The registered transaction still completes and the Ack is still pulsed.

Test Plan:
- Single fetch: IF_Req=1 with IF_Addr=0x100, M_Ready tied 1, M_RData=0x2402000A -> M_Valid in cycle 1, IF_Ack in cycle 2, IF_RData=0x2402000A, PCWre=0 in cycles 0-1 and 1 in cycle 2.
- Simultaneous requests: IF_Req and MEM_Rd (addr 0x200) rise together, M_Ready with 2-cycle latency -> MEM served first, Pipe_Stall=1 until MEM_Ack, then GNT_IF with no IDLE cycle between, IF_Ack follows.
- Store: MEM_Wr=1, MEM_BE=4'b0011, MEM_WData=0xCAFEBABE -> M_Wr=1, M_BE=4'b0011; M_WData/M_Addr stable across 3 wait cycles even though MEM_WData is changed in cycle 2; MEM_RData unchanged.
- Masking: IF_Req held high continuously across completions -> exactly one IF_Ack per transaction, and one non-IF cycle (IDLE or GNT_MEM) between consecutive fetch grants.
- Timeout: TIMEOUT=4, M_Ready held 0 on a load -> M_Valid drops after 4 cycles high, MEM_Ack and Bus_Err pulse together, MEM_RData keeps its previous value, pending IF then granted.
- Reset mid-transaction: Reset=0 while GNT_MEM waits -> M_Valid=0 immediately (asynchronous), no Ack pulses; after release with no requests, state is IDLE and PCWre=1.
